// File: rtl/d_input_conditioner.sv
// Synchronises and debounces an asynchronous raw data line into the clk domain.
// Produces the clean D level for the downstream flop, rise/fall strobes and a busy flag.
module d_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_raw,
    input  logic enable,
    output logic d_clean,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   d_sync;
    logic                   differs;

    assign d_sync  = sync_q[SYNC_STAGES-1];
    assign differs = d_sync ^ clean_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_raw};
    end

    // A matching sample or a disabled cycle discards any partial count.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (enable && differs) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = d_sync;
                rise_d  = d_sync;
                fall_d  = ~d_sync;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign d_clean = clean_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign busy    = (cnt_q != '0);

endmodule

// File: tb/tb_d_input_conditioner.sv
// Directed bench for d_input_conditioner at default parameters.
// Each scenario task drives stimulus and checks hand-derived per-edge values.
module tb_d_input_conditioner;

    logic clk;
    logic reset_n;
    logic d_raw;
    logic enable;
    logic d_clean;
    logic rise;
    logic fall;
    logic busy;

    int checks;
    int failures;

    d_input_conditioner dut (
        .clk     (clk),
        .reset_n (reset_n),
        .d_raw   (d_raw),
        .enable  (enable),
        .d_clean (d_clean),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic raw);
        reset_n = 1'b0;
        d_raw   = raw;
        enable  = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        d_raw   = 1'b1;
        enable  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if ({d_clean, rise, fall, busy} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_hold edge=%0d got=%b want=0000", i,
                         {d_clean, rise, fall, busy});
            end
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (rise !== (i == 6) || d_clean !== (i >= 6)) begin
                failures++;
                $display("FAIL reset_release edge=%0d rise=%b d_clean=%b want rise=%b d_clean=%b",
                         i, rise, d_clean, i == 6, i >= 6);
            end
        end
    endtask

    task automatic test_clean_step;
        do_reset(1'b0);
        d_raw = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (busy !== (i >= 3 && i <= 5) || rise !== (i == 6) ||
                d_clean !== (i >= 6) || fall !== 1'b0) begin
                failures++;
                $display("FAIL step_rise edge=%0d busy=%b rise=%b fall=%b d_clean=%b",
                         i, busy, rise, fall, d_clean);
            end
        end
        d_raw = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (fall !== (i == 6) || rise !== 1'b0 || d_clean !== (i < 6)) begin
                failures++;
                $display("FAIL step_fall edge=%0d fall=%b rise=%b d_clean=%b want fall=%b",
                         i, fall, rise, d_clean, i == 6);
            end
        end
    endtask

    task automatic test_glitch;
        do_reset(1'b0);
        d_raw = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 3) d_raw = 1'b0;
            checks++;
            if (d_clean !== 1'b0 || rise !== 1'b0 || busy !== (i >= 3 && i <= 5)) begin
                failures++;
                $display("FAIL glitch edge=%0d d_clean=%b rise=%b busy=%b want busy=%b",
                         i, d_clean, rise, busy, i >= 3 && i <= 5);
            end
        end
    endtask

    task automatic test_bounce;
        logic [4:0] pat;
        pat = 5'b10101;
        do_reset(1'b0);
        for (int i = 1; i <= 12; i++) begin
            d_raw = (i <= 5) ? pat[i-1] : 1'b1;
            tick();
            checks++;
            if (rise !== (i == 10) || fall !== 1'b0 || d_clean !== (i >= 10)) begin
                failures++;
                $display("FAIL bounce edge=%0d rise=%b fall=%b d_clean=%b want rise=%b",
                         i, rise, fall, d_clean, i == 10);
            end
        end
    endtask

    task automatic test_enable;
        do_reset(1'b0);
        enable = 1'b0;
        d_raw  = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (d_clean !== 1'b0 || busy !== 1'b0 || rise !== 1'b0) begin
                failures++;
                $display("FAIL enable_off edge=%0d d_clean=%b busy=%b rise=%b want 0",
                         i, d_clean, busy, rise);
            end
        end
        enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (rise !== (i == 4) || d_clean !== (i >= 4)) begin
                failures++;
                $display("FAIL enable_on edge=%0d rise=%b d_clean=%b want rise=%b",
                         i, rise, d_clean, i == 4);
            end
        end
        // Freeze a high level, then interrupt a partial count.
        enable = 1'b0;
        d_raw  = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (d_clean !== 1'b1 || fall !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL enable_hold edge=%0d d_clean=%b fall=%b busy=%b",
                         i, d_clean, fall, busy);
            end
        end
        enable = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL enable_partial busy=%b want 1", busy);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL enable_discard busy=%b want 0", busy);
        end
        enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (fall !== (i == 4) || d_clean !== (i < 4)) begin
                failures++;
                $display("FAIL enable_restart edge=%0d fall=%b d_clean=%b want fall=%b",
                         i, fall, d_clean, i == 4);
            end
        end
    endtask

    task automatic test_mid_reset;
        do_reset(1'b0);
        d_raw = 1'b1;
        for (int i = 1; i <= 4; i++) tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_arming busy=%b want 1", busy);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({d_clean, rise, fall, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_async got=%b want=0000", {d_clean, rise, fall, busy});
        end
        #2;
        reset_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (rise !== (i == 6) || d_clean !== (i >= 6)) begin
                failures++;
                $display("FAIL midrst_release edge=%0d rise=%b d_clean=%b want rise=%b",
                         i, rise, d_clean, i == 6);
            end
        end
        // Asynchronous clear from a high level while counting down.
        d_raw = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({d_clean, rise, fall, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_high got=%b want=0000", {d_clean, rise, fall, busy});
        end
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        do_reset(1'b0);
        d_raw = 1'b1;
        for (int i = 1; i <= 6; i++) tick();
        d_raw = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (fall !== (i == 6) || rise !== 1'b0) begin
                failures++;
                $display("FAIL b2b_fall edge=%0d fall=%b rise=%b want fall=%b",
                         i, fall, rise, i == 6);
            end
        end
        d_raw = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (rise !== (i == 6) || fall !== 1'b0) begin
                failures++;
                $display("FAIL b2b_rise edge=%0d rise=%b fall=%b want rise=%b",
                         i, rise, fall, i == 6);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        d_raw    = 1'b0;
        enable   = 1'b1;
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_enable();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
